// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source-domain side of a two-phase (toggle) req/ack crossing.
// A word accepted on s_valid/s_ready is held on x_data while x_req toggles;
// the block waits in WAIT_ACK until the synchronized x_ack matches x_req.
// Optional ack-timeout flag: define CDC_HANDSHAKE_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
  parameter int unsigned N       = 2,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             x_req,
  output logic [WIDTH-1:0] x_data,
  input  logic             x_ack,
  output logic             busy,
  output logic             timeout_err
);

  // Elaboration-time parameter legality checks.
  if (N < 2) begin : g_bad_n
    $error("cdc_handshake_tx: N must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cdc_handshake_tx: TIMEOUT must be >= 1");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               x_req_q, x_req_d;
  logic [WIDTH-1:0]   x_data_q, x_data_d;
  logic               s_ready_q, s_ready_d;
  logic               accept;

  (* ASYNC_REG = "TRUE", SILISCALE_CDC = "TRUE" *)
  logic [N-1:0]       ack_s_q;
  logic [N-1:0]       ack_s_d;

  // Next-state logic: accept in IDLE, complete when synchronized ack matches req.
  always_comb begin
    state_d  = state_q;
    x_req_d  = x_req_q;
    x_data_d = x_data_q;
    ack_s_d  = {ack_s_q[N-2:0], x_ack};
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && s_ready_q) begin
          accept   = 1'b1;
          x_data_d = s_data;
          x_req_d  = ~x_req_q;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s_q[N-1] == x_req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // s_ready is held low through reset and comes up on the first edge after it.
    s_ready_d = (state_d == IDLE);
  end

  // State, handshake outputs and ack synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_req_q   <= 1'b0;
      x_data_q  <= '0;
      s_ready_q <= 1'b0;
      ack_s_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_req_q   <= x_req_d;
      x_data_q  <= x_data_d;
      s_ready_q <= s_ready_d;
      ack_s_q   <= ack_s_d;
    end
  end

  assign s_ready = s_ready_q;
  assign x_req   = x_req_q;
  assign x_data  = x_data_q;
  assign busy    = (state_q == WAIT_ACK);

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  // Saturating WAIT_ACK cycle counter; flag is sticky once the limit is hit.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (accept) begin
      to_cnt_d = '0;
    end else if (state_q == WAIT_ACK && to_cnt_q != CW'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + CW'(1);
    end
    timeout_err_d = timeout_err_q | (to_cnt_d == CW'(TIMEOUT));
  end

  // Timeout counter and sticky error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with N=2, WIDTH=8, TIMEOUT=16.
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       x_req;
  logic [7:0] x_data;
  logic       x_ack;
  logic       busy;
  logic       timeout_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  cdc_handshake_tx #(
    .N(2),
    .WIDTH(8),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .x_req(x_req),
    .x_data(x_data),
    .x_ack(x_ack),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; x_ack = 1'b0;
    tick(); tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_x_req", x_req, 0);
    check("rst_x_data", x_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);

    // Reset release: s_ready rises one edge later.
    rst = 1'b0; #1;
    check("rel_s_ready_pre", s_ready, 0);
    tick();
    check("rel_s_ready", s_ready, 1);
    check("rel_x_req", x_req, 0);
    check("rel_busy", busy, 0);
    check("rel_x_data", x_data, 0);

    // First word A5.
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    check("a5_x_data", x_data, 8'hA5);
    check("a5_x_req", x_req, 1);
    check("a5_busy", busy, 1);
    check("a5_s_ready", s_ready, 0);
    s_valid = 1'b0;
    tick(); tick();
    check("a5_wait_busy", busy, 1);
    x_ack = 1'b1;
    tick();
    check("a5_j_busy", busy, 1);
    tick();
    check("a5_j1_busy", busy, 1);
    check("a5_j1_s_ready", s_ready, 0);
    tick();
    check("a5_j2_s_ready", s_ready, 1);
    check("a5_j2_busy", busy, 0);
    check("a5_j2_x_data", x_data, 8'hA5);
    check("a5_j2_x_req", x_req, 1);

    // Back-to-back word 3C, then ack withheld for 50 cycles.
    s_valid = 1'b1; s_data = 8'h3C;
    tick();
    check("3c_x_req", x_req, 0);
    check("3c_x_data", x_data, 8'h3C);
    check("3c_busy", busy, 1);
    check("3c_s_ready", s_ready, 0);
    for (int i = 1; i <= 50; i++) begin
      s_data = 8'(i + 8'h40);
      tick();
      check($sformatf("hold%0d_busy", i), busy, 1);
      check($sformatf("hold%0d_x_data", i), x_data, 8'h3C);
      check($sformatf("hold%0d_x_req", i), x_req, 0);
      check($sformatf("hold%0d_timeout", i), timeout_err, (TO_EN && i >= 16) ? 1 : 0);
    end
    s_valid = 1'b0; x_ack = 1'b0;
    tick();
    check("3c_j_busy", busy, 1);
    tick();
    check("3c_j1_busy", busy, 1);
    tick();
    check("3c_j2_s_ready", s_ready, 1);
    check("3c_j2_busy", busy, 0);
    check("3c_j2_timeout", timeout_err, TO_EN ? 1 : 0);

    // Spurious ack toggles while IDLE.
    x_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("spur1_s_ready", s_ready, 1);
      check("spur1_busy", busy, 0);
      check("spur1_x_req", x_req, 0);
    end
    x_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("spur0_s_ready", s_ready, 1);
      check("spur0_busy", busy, 0);
    end

    // Word 5A completes only on the matching ack toggle.
    s_valid = 1'b1; s_data = 8'h5A;
    tick();
    check("5a_x_req", x_req, 1);
    check("5a_busy", busy, 1);
    check("5a_x_data", x_data, 8'h5A);
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("5a_wait_busy", busy, 1);
    end
    x_ack = 1'b1;
    tick();
    check("5a_j_busy", busy, 1);
    tick();
    check("5a_j1_busy", busy, 1);
    tick();
    check("5a_j2_s_ready", s_ready, 1);
    check("5a_j2_busy", busy, 0);
    check("5a_timeout_sticky", timeout_err, TO_EN ? 1 : 0);

    // Word C3 (req back to 0).
    s_valid = 1'b1; s_data = 8'hC3;
    tick();
    check("c3_x_req", x_req, 0);
    check("c3_busy", busy, 1);
    s_valid = 1'b0; x_ack = 1'b0;
    tick(); tick();
    check("c3_j1_busy", busy, 1);
    tick();
    check("c3_done_s_ready", s_ready, 1);
    check("c3_done_busy", busy, 0);

    // Word 96, then reset mid-transfer.
    s_valid = 1'b1; s_data = 8'h96;
    tick();
    check("96_x_req", x_req, 1);
    check("96_busy", busy, 1);
    check("96_x_data", x_data, 8'h96);
    s_valid = 1'b0;
    tick();
    #2; rst = 1'b1; #1;
    check("mid_rst_x_req", x_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_x_data", x_data, 0);
    check("mid_rst_timeout", timeout_err, 0);
    tick();
    rst = 1'b0; #1;
    check("mid_rel_s_ready_pre", s_ready, 0);
    tick();
    check("mid_rel_s_ready", s_ready, 1);
    check("mid_rel_busy", busy, 0);

    // Post-reset transfer AA completes normally.
    s_valid = 1'b1; s_data = 8'hAA;
    tick();
    check("aa_x_req", x_req, 1);
    check("aa_x_data", x_data, 8'hAA);
    s_valid = 1'b0; x_ack = 1'b1;
    tick(); tick();
    check("aa_j1_busy", busy, 1);
    tick();
    check("aa_done_s_ready", s_ready, 1);
    check("aa_done_busy", busy, 0);
    check("aa_timeout", timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
